// File: rtl/jtag_pkg.sv
// Shared types for the JTAG debug transport: transaction status, size, AXI response
// and the bus-sequencer state encoding.
package jtag_pkg;

   typedef enum logic [2:0] {
      TXN_IDLE      = 3'd0,
      TXN_OK        = 3'd1,
      TXN_SLVERR    = 3'd2,
      TXN_DECERR    = 3'd3,
      TXN_TIMEOUT   = 3'd4,
      TXN_ERR_ALIGN = 3'd5
   } txn_status_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } txn_size_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } axi_resp_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_DRAIN   = 3'd5
   } txn_ctrl_fsm_t;

   function automatic txn_status_t resp_to_status(input axi_resp_t resp);
      case (resp)
         RESP_SLVERR: return TXN_SLVERR;
         RESP_DECERR: return TXN_DECERR;
         default:     return TXN_OK;
      endcase
   endfunction

   function automatic logic is_misaligned(input txn_size_t size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return off != 2'd0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] size_strb(input txn_size_t size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] size_mask(input txn_size_t size);
      case (size)
         SZ_BYTE: return 32'h0000_00FF;
         SZ_HALF: return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/jtag_axi_txn_ctrl_toggle_sync.sv
// Toggle-handshake receiver: 3-flop synchronizer, one-cycle pulse per input transition.
module toggle_sync (
   input  logic clk,
   input  logic trstn,
   input  logic tgl,
   output logic pulse
);

   logic [2:0] sync;

   always_ff @(posedge clk or negedge trstn) begin
      if (!trstn) sync <= 3'b000;
      else        sync <= {sync[1:0], tgl};
   end

   assign pulse = sync[1] ^ sync[2];

endmodule

// File: rtl/jtag_axi_txn_ctrl.sv
// Sequences one AXI4-Lite transaction per JTAG command toggle and reports status.
//
// state      | meaning
// ST_IDLE    | waiting for a command toggle
// ST_WR_REQ  | awvalid/wvalid outstanding, each drops on its own handshake
// ST_WR_RESP | bready high, waiting for bvalid
// ST_RD_REQ  | arvalid outstanding
// ST_RD_RESP | rready high, waiting for rvalid
// ST_DRAIN   | timed out; finishing outstanding handshakes, response discarded
module jtag_axi_txn_ctrl
   import jtag_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [2:0] AXI_PROT       = 3'b000
) (
   input  logic        aclk,
   input  logic        trstn,
   input  logic        cmd_req_toggle,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic [2:0]  awprot,
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic        bvalid,
   output logic        bready,
   input  logic [1:0]  bresp,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [2:0]  arprot,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   output logic        sts_busy,
   output logic [2:0]  sts_code,
   output logic [31:0] sts_rdata,
   output logic        sts_overrun,
   output logic        sts_done_toggle
);

   localparam int            TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

   txn_ctrl_fsm_t state, nxt_state;
   txn_status_t   code_q, nxt_code;
   txn_size_t     size_q, nxt_size;
   logic [1:0]    off_q, nxt_off;
   logic [31:0]   addr_q, nxt_addr;
   logic [TW-1:0] timer, nxt_timer;
   logic          is_wr_q, nxt_is_wr;
   logic          nxt_awvalid, nxt_wvalid, nxt_bready, nxt_arvalid, nxt_rready;
   logic [31:0]   nxt_wdata, nxt_rdata;
   logic [3:0]    nxt_wstrb;
   logic          nxt_overrun, nxt_done;
   logic          req_pulse, tmo;
   txn_size_t     cmd_sz;

   toggle_sync u_req_sync (
      .clk   (aclk),
      .trstn (trstn),
      .tgl   (cmd_req_toggle),
      .pulse (req_pulse)
   );

   assign cmd_sz    = txn_size_t'(cmd_size);
   assign tmo       = (timer == '0);
   assign awaddr    = addr_q;
   assign araddr    = addr_q;
   assign awprot    = AXI_PROT;
   assign arprot    = AXI_PROT;
   assign sts_code  = code_q;
   assign sts_busy  = (state != ST_IDLE);

   always_comb begin
      nxt_state   = state;
      nxt_code    = code_q;
      nxt_size    = size_q;
      nxt_off     = off_q;
      nxt_addr    = addr_q;
      nxt_timer   = timer;
      nxt_is_wr   = is_wr_q;
      nxt_awvalid = awvalid;
      nxt_wvalid  = wvalid;
      nxt_bready  = bready;
      nxt_arvalid = arvalid;
      nxt_rready  = rready;
      nxt_wdata   = wdata;
      nxt_wstrb   = wstrb;
      nxt_rdata   = sts_rdata;
      nxt_overrun = sts_overrun;
      nxt_done    = sts_done_toggle;

      case (state)
         ST_IDLE: begin
            if (req_pulse) begin
               nxt_overrun = 1'b0;
               if (is_misaligned(cmd_sz, cmd_addr[1:0])) begin
                  nxt_code = TXN_ERR_ALIGN;
                  nxt_done = ~sts_done_toggle;
               end else begin
                  nxt_addr  = cmd_addr;
                  nxt_off   = cmd_addr[1:0];
                  nxt_size  = cmd_sz;
                  nxt_is_wr = cmd_write;
                  nxt_timer = TIMER_LOAD;
                  if (cmd_write) begin
                     nxt_awvalid = 1'b1;
                     nxt_wvalid  = 1'b1;
                     nxt_wstrb   = size_strb(cmd_sz, cmd_addr[1:0]);
                     nxt_wdata   = cmd_wdata << {cmd_addr[1:0], 3'b000};
                     nxt_state   = ST_WR_REQ;
                  end else begin
                     nxt_arvalid = 1'b1;
                     nxt_state   = ST_RD_REQ;
                  end
               end
            end
         end
         ST_WR_REQ: begin
            nxt_awvalid = awvalid & ~awready;
            nxt_wvalid  = wvalid & ~wready;
            if (!nxt_awvalid && !nxt_wvalid) begin
               nxt_bready = 1'b1;
               nxt_timer  = TIMER_LOAD;
               nxt_state  = ST_WR_RESP;
            end else if ((awvalid && awready) || (wvalid && wready)) begin
               nxt_timer = TIMER_LOAD;
            end else if (tmo) begin
               nxt_code  = TXN_TIMEOUT;
               nxt_done  = ~sts_done_toggle;
               nxt_state = ST_DRAIN;
            end else begin
               nxt_timer = timer - TW'(1);
            end
         end
         ST_WR_RESP: begin
            if (bvalid) begin
               nxt_bready = 1'b0;
               nxt_code   = resp_to_status(axi_resp_t'(bresp));
               nxt_done   = ~sts_done_toggle;
               nxt_state  = ST_IDLE;
            end else if (tmo) begin
               nxt_code  = TXN_TIMEOUT;
               nxt_done  = ~sts_done_toggle;
               nxt_state = ST_DRAIN;
            end else begin
               nxt_timer = timer - TW'(1);
            end
         end
         ST_RD_REQ: begin
            if (arready) begin
               nxt_arvalid = 1'b0;
               nxt_rready  = 1'b1;
               nxt_timer   = TIMER_LOAD;
               nxt_state   = ST_RD_RESP;
            end else if (tmo) begin
               nxt_code  = TXN_TIMEOUT;
               nxt_done  = ~sts_done_toggle;
               nxt_state = ST_DRAIN;
            end else begin
               nxt_timer = timer - TW'(1);
            end
         end
         ST_RD_RESP: begin
            if (rvalid) begin
               nxt_rready = 1'b0;
               nxt_code   = resp_to_status(axi_resp_t'(rresp));
               nxt_rdata  = (rdata >> {off_q, 3'b000}) & size_mask(size_q);
               nxt_done   = ~sts_done_toggle;
               nxt_state  = ST_IDLE;
            end else if (tmo) begin
               nxt_code  = TXN_TIMEOUT;
               nxt_done  = ~sts_done_toggle;
               nxt_state = ST_DRAIN;
            end else begin
               nxt_timer = timer - TW'(1);
            end
         end
         ST_DRAIN: begin
            // Status was already reported at the timeout; only the bus is tidied up here.
            nxt_awvalid = awvalid & ~awready;
            nxt_wvalid  = wvalid & ~wready;
            nxt_arvalid = arvalid & ~arready;
            if (is_wr_q) begin
               if (bready && bvalid) begin
                  nxt_bready = 1'b0;
                  nxt_state  = ST_IDLE;
               end else if (!nxt_awvalid && !nxt_wvalid) begin
                  nxt_bready = 1'b1;
               end
            end else begin
               if (rready && rvalid) begin
                  nxt_rready = 1'b0;
                  nxt_state  = ST_IDLE;
               end else if (!nxt_arvalid) begin
                  nxt_rready = 1'b1;
               end
            end
         end
         default: nxt_state = ST_IDLE;
      endcase

      if (req_pulse && state != ST_IDLE) nxt_overrun = 1'b1;
   end

   always_ff @(posedge aclk or negedge trstn) begin
      if (!trstn) begin
         state           <= ST_IDLE;
         code_q          <= TXN_IDLE;
         size_q          <= SZ_BYTE;
         off_q           <= 2'd0;
         addr_q          <= '0;
         timer           <= '0;
         is_wr_q         <= 1'b0;
         awvalid         <= 1'b0;
         wvalid          <= 1'b0;
         bready          <= 1'b0;
         arvalid         <= 1'b0;
         rready          <= 1'b0;
         wdata           <= '0;
         wstrb           <= '0;
         sts_rdata       <= '0;
         sts_overrun     <= 1'b0;
         sts_done_toggle <= 1'b0;
      end else begin
         state           <= nxt_state;
         code_q          <= nxt_code;
         size_q          <= nxt_size;
         off_q           <= nxt_off;
         addr_q          <= nxt_addr;
         timer           <= nxt_timer;
         is_wr_q         <= nxt_is_wr;
         awvalid         <= nxt_awvalid;
         wvalid          <= nxt_wvalid;
         bready          <= nxt_bready;
         arvalid         <= nxt_arvalid;
         rready          <= nxt_rready;
         wdata           <= nxt_wdata;
         wstrb           <= nxt_wstrb;
         sts_rdata       <= nxt_rdata;
         sts_overrun     <= nxt_overrun;
         sts_done_toggle <= nxt_done;
      end
   end

endmodule

// File: doc/jtag_axi_txn_ctrl.md
Name: jtag_axi_txn_ctrl

Overview:
AXI4-Lite master sequencer that turns JTAG-side transaction commands into single bus transactions. JTAG data registers supply address, write data and size; this block issues the transaction and returns read data and status. It sits between the JTAG data-register logic (tck domain) and the system interconnect (aclk domain). Handoff uses a toggle handshake.

Parameters:
TIMEOUT_CYCLES, 1024, aclk cycles waited for any single AXI handshake before reporting TIMEOUT (≥2)
AXI_PROT, 3'b000, constant driven on awprot/arprot

Ports:
aclk  in  1  system/AXI clock
trstn  in  1  reset, asynchronous, active-low
cmd_req_toggle  in  1  tck-domain toggle; each transition requests one transaction
cmd_write  in  1  1=write, 0=read; quasi-static, sampled at request detect
cmd_size  in  2  0=byte, 1=half, 2=word, 3=reserved
cmd_addr  in  32  target address; quasi-static
cmd_wdata  in  32  write data, LSB-aligned; quasi-static
awvalid/awready/awaddr[31:0]/awprot[2:0]  AXI4-Lite write address
wvalid/wready/wdata[31:0]/wstrb[3:0]  AXI4-Lite write data
bvalid/bready/bresp[1:0]  AXI4-Lite write response
arvalid/arready/araddr[31:0]/arprot[2:0]  AXI4-Lite read address
rvalid/rready/rdata[31:0]/rresp[1:0]  AXI4-Lite read data
sts_busy  out  1  transaction in flight or draining
sts_code  out  3  txn_status_t of last completed command
sts_rdata  out  32  read data of last read, right-aligned per size
sts_overrun  out  1  sticky: request arrived while busy; cleared by next accepted request
sts_done_toggle  out  1  toggles once per completed or aborted command

Behaviour:
- Reset (trstn low, async): FSM=IDLE; all valid/ready outputs 0; awaddr/araddr/wdata/wstrb 0; sts_busy 0, sts_code IDLE(0), sts_rdata 0, sts_overrun 0, sts_done_toggle 0; synchronizer flops 0. Reset mid-transaction abandons it silently; the interconnect is assumed reset together.
- Request detect: 3-flop chain on cmd_req_toggle; req_pulse = ff2 ^ ff3. Toggle at edge N → pulse valid after edge N+2 → latch cmd_* at edge N+3, valids high after N+3.
- Request while FSM≠IDLE: dropped, sts_overrun←1.
- Decode on latch: misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=3 → no bus access, sts_code=ERR_ALIGN, toggle done, stay IDLE.
- wstrb: byte=4'b0001<<a[1:0], half=4'b0011<<a[1:0], word=4'b1111. wdata = cmd_wdata shifted left by 8*a[1:0]. Address driven unmodified.
- States: IDLE → WR_REQ | RD_REQ → WR_RESP | RD_RESP → IDLE; also DRAIN.
- WR_REQ: awvalid and wvalid rise together, each drops independently on its own handshake; both must be done → WR_RESP (bready=1). bvalid → capture bresp → IDLE.
- RD_REQ: arvalid until arready → RD_RESP (rready=1); rvalid → capture rresp, rdata >> 8*a[1:0], masked to size → IDLE.
- Valids never deasserted before the matching ready (AXI rule).
- Completion: sts_code from resp: OKAY→OK, EXOKAY→OK, SLVERR→SLVERR, DECERR→DECERR; sts_done_toggle flips on the same edge that returns to IDLE. sts_rdata updated only by reads with any response.
- Timeout: counter clears on entry to each wait state and on every handshake. At TIMEOUT_CYCLES-1 with no handshake → sts_code=TIMEOUT, toggle done, → DRAIN. DRAIN holds outstanding valids and readies until all handshakes finish, discards the response, → IDLE. sts_busy=1 throughout DRAIN.
- sts_busy = (FSM≠IDLE).
- sts_* change only at completion, except sts_busy and sts_overrun.
- Back-to-back: a new toggle may be accepted the cycle after return to IDLE.

Decomposition:
- jtag_pkg gains: txn_status_t (IDLE=0, OK=1, SLVERR=2, DECERR=3, TIMEOUT=4, ERR_ALIGN=5), txn_size_t, axi_resp_t, txn_ctrl_fsm_t.
- Sub-module toggle_sync: 3-flop synchronizer + edge pulse. Also reusable for sts_done_toggle on the tck side.

Test Plan:
- Word write: toggle, write=1, size=2, addr 0x1000_0004, wdata 0xDEAD_BEEF, slave ready immediately → awaddr 0x1000_0004, wstrb 4'hF, wdata 0xDEADBEEF; bresp OKAY → sts_code=1, done toggles once, busy low.
- Byte read: size=0, addr 0x2000_0003; slave returns rdata 0xAB00_0000 after 5-cycle arready delay → araddr 0x2000_0003, sts_rdata=0x0000_00AB, sts_code=1.
- Byte write with staggered ready: addr …02, wdata 0x5A; wready 3 cycles before awready → wstrb 4'b0100, wdata 0x005A_0000; each valid drops only on its own handshake; bresp SLVERR → sts_code=2.
- Misaligned: size=2, addr 0x…02 → no awvalid/arvalid ever; sts_code=5; done toggles.
- Timeout: TIMEOUT_CYCLES=8, arready held low → sts_code=4, done toggles at cycle 8. Then arready/rvalid given → handshakes complete, rdata discarded, sts_rdata unchanged, busy falls.
- Overrun and reset: second toggle during pending read → sts_overrun=1, only one transaction issued. Assert trstn mid-WR_REQ → all outputs return to reset values immediately.
